// File: rtl/ram_arb_pkg.sv
// Shared opcodes and FSM state type for the two-requester RAM command arbiter.
package ram_arb_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      RWAIT,
      DONE
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; 'last' remembers the previous winner so that
// simultaneous requests alternate. Single requests win regardless of pointer.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant,
   output logic       valid
);

   logic last;

   always_comb begin
      valid = |req;
      grant = (req == 2'b11) ? ~last : req[1];
   end

   // Reset to "r1 granted last" so the first contended grant goes to r0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (update && valid)
         last <= grant;
   end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares a command-driven single-port RAM between two requesters, turning each
// request into an addr/data opcode pair. Optional RAM_ADDR_SKIP_EN skips repeated ADDR commands.
module ram_cmd_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic              r0_err,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic              r1_err,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W+1:0] ram_din,
   output logic              ram_rx_valid,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_tx_valid,
   output logic              busy
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   state_t            state, state_nx;
   logic              grant, req_any;
   logic              gnt_q, we_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic              rd_timeout, skip_addr;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({r1_req, r0_req}),
      .update (state == IDLE),
      .grant  (grant),
      .valid  (req_any)
   );

   assign sel_we     = grant ? r1_we    : r0_we;
   assign sel_addr   = grant ? r1_addr  : r0_addr;
   assign sel_wdata  = grant ? r1_wdata : r0_wdata;
   assign rd_timeout = (cnt == CNT_W'(RD_TIMEOUT - 1));

`ifdef RAM_ADDR_SKIP_EN
   logic [ADDR_W-1:0] wr_shadow, rd_shadow;
   logic              wr_shadow_v, rd_shadow_v;

   // NOTE: shadows are plain flops, not a memory, so resetting them costs nothing and keeps valid bits honest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_shadow   <= '0;
         rd_shadow   <= '0;
         wr_shadow_v <= 1'b0;
         rd_shadow_v <= 1'b0;
      end else if (state == ADDR) begin
         if (we_q) begin
            wr_shadow   <= addr_q;
            wr_shadow_v <= 1'b1;
         end else begin
            rd_shadow   <= addr_q;
            rd_shadow_v <= 1'b1;
         end
      end
   end

   assign skip_addr = sel_we ? (wr_shadow_v && (wr_shadow == sel_addr))
                             : (rd_shadow_v && (rd_shadow == sel_addr));
`else
   assign skip_addr = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nx     = state;
      ram_rx_valid = 1'b0;
      ram_din      = '0;
      busy         = (state != IDLE);
      r0_ack       = 1'b0;
      r1_ack       = 1'b0;
      r0_err       = 1'b0;
      r1_err       = 1'b0;
      case (state)
         IDLE:  if (req_any) state_nx = skip_addr ? DATA : ADDR;
         ADDR: begin
            ram_rx_valid = 1'b1;
            ram_din      = {(we_q ? CMD_WR_ADDR : CMD_RD_ADDR), addr_q};
            state_nx     = DATA;
         end
         DATA: begin
            ram_rx_valid = 1'b1;
            ram_din      = we_q ? {CMD_WR_DATA, wdata_q} : {CMD_RD_DATA, {DATA_W{1'b0}}};
            state_nx     = we_q ? DONE : RWAIT;
         end
         RWAIT: if (ram_tx_valid || rd_timeout) state_nx = DONE;
         DONE: begin
            r0_ack   = ~gnt_q;
            r1_ack   = gnt_q;
            r0_err   = ~gnt_q & err_q;
            r1_err   = gnt_q & err_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         cnt      <= '0;
         r0_rdata <= '0;
         r1_rdata <= '0;
      end else begin
         case (state)
            IDLE: if (req_any) begin
               gnt_q   <= grant;
               we_q    <= sel_we;
               addr_q  <= sel_addr;
               wdata_q <= sel_wdata;
               err_q   <= 1'b0;
            end
            DATA: cnt <= '0;
            RWAIT: begin
               // Read data lands in the granted requester's register as DONE begins.
               if (ram_tx_valid || rd_timeout) begin
                  err_q <= ~ram_tx_valid;
                  if (gnt_q) r1_rdata <= ram_tx_valid ? ram_dout : '0;
                  else       r0_rdata <= ram_tx_valid ? ram_dout : '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: directed cases plus randomized traffic against
// a transaction-level model (expected latency, command list, data). Honors RAM_ADDR_SKIP_EN.
module tb_ram_cmd_arbiter;

   localparam int RD_TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0_req, r0_we, r1_req, r1_we;
   logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic       r0_ack, r0_err, r1_ack, r1_err;
   logic [7:0] r0_rdata, r1_rdata;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic [7:0] ram_dout;
   logic       ram_tx_valid;
   logic       busy;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   ram_cmd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .r0_req       (r0_req),
      .r0_we        (r0_we),
      .r0_addr      (r0_addr),
      .r0_wdata     (r0_wdata),
      .r0_ack       (r0_ack),
      .r0_err       (r0_err),
      .r0_rdata     (r0_rdata),
      .r1_req       (r1_req),
      .r1_we        (r1_we),
      .r1_addr      (r1_addr),
      .r1_wdata     (r1_wdata),
      .r1_ack       (r1_ack),
      .r1_err       (r1_err),
      .r1_rdata     (r1_rdata),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM environment: commands sampled at the rising edge, read data returned the following cycle.
   logic [7:0] ram_mem [256];
   bit         rsp_en = 1'b1;

   initial begin
      logic [7:0] wa, ra;
      bit         pend;
      wa = 8'h00;
      ra = 8'h00;
      pend = 1'b0;
      ram_tx_valid = 1'b0;
      ram_dout = 8'h00;
      foreach (ram_mem[i]) ram_mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         if (ram_rx_valid) begin
            case (ram_din[9:8])
               2'b00: wa = ram_din[7:0];
               2'b01: ram_mem[wa] = ram_din[7:0];
               2'b10: ra = ram_din[7:0];
               default: pend = rsp_en;
            endcase
         end
         @(negedge clk);
         ram_tx_valid = pend;
         ram_dout = pend ? ram_mem[ra] : 8'h00;
         pend = 1'b0;
      end
   end

   // Reference model: contents as written by completed transactions plus last-ADDR shadows.
   logic [7:0] exp_mem [256];
   bit         wsh_v, rsh_v;
   logic [7:0] wsh, rsh;

   task automatic drive_req(input int n, input bit on, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata);
      if (n == 0) begin
         r0_req = on; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = on; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      end
   endtask

   task automatic txn(input int n, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                      input bit rsp, input string tag);
      bit         skip, acked;
      int         exp_lat, cyc;
      logic [9:0] exp_cmd[$];
      logic [9:0] got_cmd[$];
      logic [9:0] gc;
      skip = 1'b0;
`ifdef RAM_ADDR_SKIP_EN
      skip = we ? (wsh_v && wsh == addr) : (rsh_v && rsh == addr);
`endif
      if (!skip) exp_cmd.push_back({(we ? 2'b00 : 2'b10), addr});
      exp_cmd.push_back(we ? {2'b01, wdata} : {2'b11, 8'h00});
      exp_lat = we ? 3 : (rsp ? 4 : 3 + RD_TIMEOUT);
      if (skip) exp_lat--;
      rsp_en = rsp;

      @(negedge clk);
      drive_req(n, 1'b1, we, addr, wdata);
      cyc = 0;
      acked = 1'b0;
      while (!acked && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (ram_rx_valid) got_cmd.push_back(ram_din);
         check({tag, "_dual_ack"}, {31'd0, r0_ack & r1_ack}, 32'd0);
         acked = (n == 0) ? r0_ack : r1_ack;
      end
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_other_ack"}, {31'd0, (n == 0) ? r1_ack : r0_ack}, 32'd0);
      check({tag, "_err"}, {31'd0, (n == 0) ? r0_err : r1_err}, {31'd0, (!we && !rsp)});
      if (!we)
         check({tag, "_rdata"}, (n == 0) ? r0_rdata : r1_rdata, rsp ? exp_mem[addr] : 8'h00);
      check({tag, "_cmd_count"}, got_cmd.size(), exp_cmd.size());
      for (int i = 0; i < exp_cmd.size(); i++) begin
         gc = (i < got_cmd.size()) ? got_cmd[i] : 10'h3ff;
         check({tag, "_cmd"}, gc, exp_cmd[i]);
      end
      drive_req(n, 1'b0, we, addr, wdata);

      if (!skip) begin
         if (we) begin wsh = addr; wsh_v = 1'b1; end
         else    begin rsh = addr; rsh_v = 1'b1; end
      end
      if (we) exp_mem[addr] = wdata;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      wsh_v = 1'b0;
      rsh_v = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int         order[$];
      int         cyc, n;
      bit         we, rsp;
      logic [7:0] addr, wd;

      foreach (exp_mem[i]) exp_mem[i] = 8'h00;
      wsh = 8'h00;
      rsh = 8'h00;
      drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset values
      rst = 1'b1;
      #1;
      check("rst_ack", {r1_ack, r0_ack}, 0);
      check("rst_err", {r1_err, r0_err}, 0);
      check("rst_rdata", {r1_rdata, r0_rdata}, 0);
      check("rst_din", ram_din, 0);
      check("rst_rx_valid", ram_rx_valid, 0);
      check("rst_busy", busy, 0);
      apply_reset();

      // Write then read back; read timeout
      txn(0, 1'b1, 8'h12, 8'hA5, 1'b1, "t1_wr");
      txn(1, 1'b0, 8'h12, 8'h00, 1'b1, "t2_rd");
      txn(1, 1'b0, 8'h12, 8'h00, 1'b0, "t4_timeout");

      // Simultaneous held requests from reset alternate r0,r1,r0,r1
      apply_reset();
      @(negedge clk);
      drive_req(0, 1'b1, 1'b1, 8'h30, 8'h5C);
      drive_req(1, 1'b1, 1'b1, 8'h31, 8'hC3);
      cyc = 0;
      while (order.size() < 4 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         check("t3_dual_ack", {31'd0, r0_ack & r1_ack}, 32'd0);
         if (r0_ack) order.push_back(0);
         if (r1_ack) order.push_back(1);
      end
      drive_req(0, 1'b0, 1'b1, 8'h30, 8'h5C);
      drive_req(1, 1'b0, 1'b1, 8'h31, 8'hC3);
      check("t3_ack_count", order.size(), 4);
      for (int i = 0; i < 4; i++)
         check("t3_order", (i < order.size()) ? order[i] : -1, i % 2);
      exp_mem[8'h30] = 8'h5C;
      exp_mem[8'h31] = 8'hC3;
      wsh = 8'h31;
      wsh_v = 1'b1;
      txn(1, 1'b0, 8'h30, 8'h00, 1'b1, "t3_rd30");
      txn(0, 1'b0, 8'h31, 8'h00, 1'b1, "t3_rd31");

      // Reset during the DATA cycle of a write
      @(negedge clk);
      drive_req(0, 1'b1, 1'b1, 8'h77, 8'h99);
      cyc = 0;
      while (!(ram_rx_valid && ram_din[9:8] == 2'b01) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_reached_data", {31'd0, ram_rx_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_rx_valid", ram_rx_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_ack", r0_ack, 0);
      check("t5_din", ram_din, 0);
      drive_req(0, 1'b0, 1'b1, 8'h77, 8'h99);
      wsh_v = 1'b0;
      rsh_v = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_ack", {r1_ack, r0_ack}, 0);
      end
      txn(0, 1'b0, 8'h77, 8'h00, 1'b1, "t5_fresh_rd");
      txn(1, 1'b1, 8'h77, 8'h66, 1'b1, "t5_fresh_wr");

      // Repeated read of one address (ADDR skipped when the shadow feature is built in)
      txn(0, 1'b1, 8'h40, 8'h3C, 1'b1, "t6_wr");
      txn(1, 1'b0, 8'h40, 8'h00, 1'b1, "t6_rd_a");
      txn(0, 1'b0, 8'h40, 8'h00, 1'b1, "t6_rd_b");

      // Randomized traffic over a small address window to exercise reuse
      for (int i = 0; i < 24; i++) begin
         n    = int'($urandom_range(0, 1));
         we   = bit'($urandom_range(0, 1));
         addr = 8'h40 + 8'($urandom_range(0, 3));
         wd   = 8'($urandom);
         rsp  = ($urandom_range(0, 5) != 0);
         txn(n, we, addr, wd, rsp, "rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
